pf_vf_rtable_lookup: RTL and testbench
======================================

# pf_vf_rtable_lookup

Runtime-programmable PF/VF routing table for the AFU PF/VF MUX path. It replaces the compile-time routing table with a CSR-writable table of entries plus a pipelined lookup engine. The engine maps an incoming (pf, vf, vf_active) tuple to a MUX port on several independent lookup channels. It sits between the PCIe SS TLP header decode and the PF/VF MUX port-select logic in afu_top.

## Interface
- NUM_ENTRIES, 16: table depth; must be at least 1.
- NUM_PORTS, 8: number of MUX ports; port field width is PORT_W = max(1, $clog2(NUM_PORTS)).
- PF_WIDTH, 3: PF number width.
- VF_WIDTH, 11: VF number width.
- NUM_CH, 2: number of independent lookup channels.
- DEFAULT_PORT, 0: port returned on a miss; must be less than NUM_PORTS.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- wr_en  in  1  table write strobe.
- wr_idx  in  $clog2(NUM_ENTRIES)  entry index to write.
- wr_entry  in  t_rtable_entry  entry contents: valid, pf, vf, vf_active, port.
- rd_idx  in  $clog2(NUM_ENTRIES)  readback index.
- rd_entry  out  t_rtable_entry  registered readback of entry rd_idx.
- req_valid / req_ready  in / out  NUM_CH  per-channel request handshake.
- req_pf, req_vf, req_vf_active  in  NUM_CH x (PF_WIDTH, VF_WIDTH, 1)  lookup key.
- resp_valid / resp_ready  out / in  NUM_CH  per-channel response handshake.
- resp_port  out  NUM_CH x PORT_W  resolved port.
- resp_hit  out  NUM_CH  1 = table hit; 0 = miss, resp_port = DEFAULT_PORT.
- miss_cnt  out  NUM_CH x 16  per-channel saturating miss counter.
- miss_cnt_clr  in  1  synchronous clear of all miss counters.

## Operation
- An entry matches a key when all of the following hold:
  - valid = 1;
  - pf is equal;
  - vf_active is equal;
  - if vf_active = 1, vf is also equal. vf is ignored when vf_active = 0.
- If several entries match, the lowest index wins. If no entry matches, resp_hit = 0 and resp_port = DEFAULT_PORT.
- Reset contents: entry i has pf = 0, vf = i, vf_active = 1, port = i mod NUM_PORTS, and valid = (i < NUM_PORTS). This is the straight PF0-VF map.
- Writes go to one entry per cycle. An out-of-range wr_idx (NUM_ENTRIES not a power of 2) is dropped.
- A write in cycle N is seen by requests accepted in cycle N+1 or later.
- A request accepted in the same cycle as a write sees the old contents.
- A request already in the pipeline is not re-evaluated.
- Channels are fully independent: no arbitration and no cross-channel stalls.

## Timing
- Each channel is a 2-stage pipeline:
  - S1 registers the per-entry match vector and the key.
  - S2 registers the priority-encoded port and hit flag.
- Latency: request accepted in cycle N gives resp_valid in cycle N+2 if there is no backpressure.
- Throughput: 1 lookup per channel per cycle.
- Advance rules:
  - s2 advances when !s2_valid || resp_ready.
  - s1 advances when s2 advances.
  - req_ready = !s1_valid || s2 advances (combinational from resp_ready, no skid).
- Response hold: while resp_valid && !resp_ready, resp_port and resp_hit are held stable.
- Reset values: req_ready 1, resp_valid 0, resp_port 0, resp_hit 0, rd_entry equals reset entry 0, miss_cnt 0.
- Reset mid-operation flushes all pipeline stages; in-flight lookups are lost.
- rd_entry is valid 1 cycle after rd_idx. It reflects a same-cycle write one cycle later.
- miss_cnt:
  - Increments on each miss response handshake (resp_valid && resp_ready && !resp_hit).
  - Saturates at 16'hFFFF.
  - miss_cnt_clr wins over a simultaneous increment; the counter becomes 0.

## Configuration
- PF_VF_RTABLE_MISS_CNT_EN:
  - Defined: the miss counters and clear logic are built.
  - Undefined: miss_cnt is tied to 0 and miss_cnt_clr is ignored.
  - Ports exist in both cases. Lookup behaviour is identical.

## Structure
- Package pf_vf_rtable_pkg holds:
  - Typedef t_rtable_entry (packed: valid, pf, vf, vf_active, port), parametrised via package localparams derived from top_cfg_pkg widths.
  - Function for the reset-table initialiser.
  - Miss-counter width constant (16).
- Sub-module pf_vf_rtable_match: one instance per channel. Contains the 2-stage pipeline, the lowest-index priority encoder and the optional miss counter. The table register array and write/readback logic stay in the top.

## Test plan
- Reset then lookups: key (pf0, vf5, active) returns port 5, hit, 2-cycle latency. Key (pf1, vf_active = 0) returns port DEFAULT_PORT = 0, hit = 0.
- Write entry 3 = {valid, pf1, vf_active = 0, port 6}, then key (pf1, vf 123, inactive): port 6, hit = 1, vf is ignored.
- Entries 2 and 9 both match (pf2, pf-only): port taken from entry 2. Invalidate entry 2: next lookup returns entry 9's port.
- Write and request in the same cycle: the request gets the old port. A request one cycle later gets the new port.
- Hold resp_ready = 0 for 5 cycles with requests streaming on channel 0:
  - Channel 0 accepts exactly 2 requests, then req_ready = 0 and the response is held stable.
  - Channel 1 keeps full throughput.
- With PF_VF_RTABLE_MISS_CNT_EN defined:
  - 70000 misses leave miss_cnt at 16'hFFFF.
  - miss_cnt_clr asserted in the same cycle as a miss handshake leaves 0.
  - With the macro undefined, miss_cnt stays 0.

Source files
------------

// File: rtl/pf_vf_rtable_pkg.sv
// Purpose  : shared types and constants for the runtime-programmable PF/VF routing table.
// Latency  : n/a (types, constants and the reset-table initialiser only).
// Backpres.: n/a.
// Contents : t_rtable_entry, entry field widths, MISS_CNT_W, rtable_reset_entry().
package pf_vf_rtable_pkg;

   localparam int RT_PF_W      = 3;
   localparam int RT_VF_W      = 11;
   localparam int RT_NUM_PORTS = 8;
   localparam int RT_PORT_W    = (RT_NUM_PORTS > 1) ? $clog2(RT_NUM_PORTS) : 1;
   localparam int MISS_CNT_W   = 16;

   typedef struct packed {
      logic                 valid;
      logic [RT_PF_W-1:0]   pf;
      logic [RT_VF_W-1:0]   vf;
      logic                 vf_active;
      logic [RT_PORT_W-1:0] port;
   } t_rtable_entry;

   // Straight PF0-VF map: entry i routes PF0/VFi to port i; only the first
   // num_ports entries start out valid.
   function automatic t_rtable_entry rtable_reset_entry(input int idx, input int num_ports);
      t_rtable_entry e;
      e.valid     = (idx < num_ports);
      e.pf        = '0;
      e.vf        = RT_VF_W'(idx);
      e.vf_active = 1'b1;
      e.port      = RT_PORT_W'(idx % num_ports);
      return e;
   endfunction

endpackage

// File: rtl/pf_vf_rtable_match.sv
// Purpose  : one lookup channel: per-entry match, lowest-index priority encode, optional miss counter.
// Latency  : 2 cycles (S1 match vector, S2 encoded port/hit); 1 lookup per cycle.
// Backpres.: S2 holds while resp_valid && !resp_ready; req_ready is combinational from resp_ready, no skid.
// Ports    : clk/rst_n, tbl (whole table), req_* key handshake, resp_* result handshake,
//            miss_cnt/miss_cnt_clr (counter built only with PF_VF_RTABLE_MISS_CNT_EN).
module pf_vf_rtable_match
   import pf_vf_rtable_pkg::*;
#(
   parameter int NUM_ENTRIES  = 16,
   parameter int PF_WIDTH     = RT_PF_W,
   parameter int VF_WIDTH     = RT_VF_W,
   parameter int PORT_W       = RT_PORT_W,
   parameter int DEFAULT_PORT = 0
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  t_rtable_entry [NUM_ENTRIES-1:0]     tbl,
   input  logic                                req_valid,
   output logic                                req_ready,
   input  logic [PF_WIDTH-1:0]                 req_pf,
   input  logic [VF_WIDTH-1:0]                 req_vf,
   input  logic                                req_vf_active,
   output logic                                resp_valid,
   input  logic                                resp_ready,
   output logic [PORT_W-1:0]                   resp_port,
   output logic                                resp_hit,
   output logic [MISS_CNT_W-1:0]               miss_cnt,
   input  logic                                miss_cnt_clr
);

   logic                               s1_valid;
   logic [NUM_ENTRIES-1:0]             s1_match;
   // Port fields are snapshotted with the match vector so a table write that
   // lands while a lookup sits in S1 cannot change that lookup's answer.
   logic [NUM_ENTRIES-1:0][PORT_W-1:0] s1_ports;

   logic                               s2_valid;
   logic [PORT_W-1:0]                  s2_port;
   logic                               s2_hit;

   logic                               s2_adv;
   logic [NUM_ENTRIES-1:0]             match_vec;
   logic [NUM_ENTRIES-1:0][PORT_W-1:0] port_vec;
   logic [PORT_W-1:0]                  enc_port;
   logic                               enc_hit;

   assign s2_adv    = !s2_valid || resp_ready;
   assign req_ready = !s1_valid || s2_adv;

   // vf only participates when the key and the entry both describe a VF.
   always_comb begin
      match_vec = '0;
      port_vec  = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         match_vec[i] = tbl[i].valid
                     && (tbl[i].pf == req_pf)
                     && (tbl[i].vf_active == req_vf_active)
                     && (!req_vf_active || (tbl[i].vf == req_vf));
         port_vec[i]  = tbl[i].port;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_match <= '0;
         s1_ports <= '0;
      end else if (req_ready) begin
         s1_valid <= req_valid;
         if (req_valid) begin
            s1_match <= match_vec;
            s1_ports <= port_vec;
         end
      end
   end

   // Scan high to low so the lowest matching index is the last to assign.
   always_comb begin
      enc_hit  = |s1_match;
      enc_port = PORT_W'(DEFAULT_PORT);
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (s1_match[i]) enc_port = s1_ports[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_port  <= '0;
         s2_hit   <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_port <= enc_port;
            s2_hit  <= enc_hit;
         end
      end
   end

   assign resp_valid = s2_valid;
   assign resp_port  = s2_port;
   assign resp_hit   = s2_hit;

`ifdef PF_VF_RTABLE_MISS_CNT_EN
   logic [MISS_CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (miss_cnt_clr) begin
         cnt_q <= '0;
      end else if (s2_valid && resp_ready && !s2_hit && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign miss_cnt = cnt_q;
`else
   logic unused_miss_cnt_clr;
   assign unused_miss_cnt_clr = miss_cnt_clr;
   assign miss_cnt            = '0;
`endif

endmodule

// File: rtl/pf_vf_rtable_lookup.sv
// Purpose  : CSR-writable PF/VF -> MUX port routing table with NUM_CH independent lookup channels.
// Latency  : lookup 2 cycles per channel; rd_entry 1 cycle after rd_idx; writes visible next cycle.
// Backpres.: per-channel valid/ready, each channel stalls only on its own resp_ready.
// Ports    : wr_en/wr_idx/wr_entry table write, rd_idx/rd_entry readback, req_*/resp_* per channel,
//            miss_cnt/miss_cnt_clr per-channel miss counters (built with PF_VF_RTABLE_MISS_CNT_EN).
module pf_vf_rtable_lookup
   import pf_vf_rtable_pkg::*;
#(
   parameter int NUM_ENTRIES  = 16,
   parameter int NUM_PORTS    = RT_NUM_PORTS,
   parameter int PF_WIDTH     = RT_PF_W,
   parameter int VF_WIDTH     = RT_VF_W,
   parameter int NUM_CH       = 2,
   parameter int DEFAULT_PORT = 0,
   localparam int PORT_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
   localparam int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 wr_en,
   input  logic [IDX_W-1:0]                     wr_idx,
   input  t_rtable_entry                        wr_entry,
   input  logic [IDX_W-1:0]                     rd_idx,
   output t_rtable_entry                        rd_entry,
   input  logic [NUM_CH-1:0]                    req_valid,
   output logic [NUM_CH-1:0]                    req_ready,
   input  logic [NUM_CH-1:0][PF_WIDTH-1:0]      req_pf,
   input  logic [NUM_CH-1:0][VF_WIDTH-1:0]      req_vf,
   input  logic [NUM_CH-1:0]                    req_vf_active,
   output logic [NUM_CH-1:0]                    resp_valid,
   input  logic [NUM_CH-1:0]                    resp_ready,
   output logic [NUM_CH-1:0][PORT_W-1:0]        resp_port,
   output logic [NUM_CH-1:0]                    resp_hit,
   output logic [NUM_CH-1:0][MISS_CNT_W-1:0]    miss_cnt,
   input  logic                                 miss_cnt_clr
);

   t_rtable_entry [NUM_ENTRIES-1:0] tbl;
   logic                            wr_ok;
   logic                            rd_ok;

   // Index range checks are only needed when the depth leaves unused codes.
   if ((2 ** IDX_W) == NUM_ENTRIES) begin : g_idx_full
      assign wr_ok = wr_en;
      assign rd_ok = 1'b1;
   end else begin : g_idx_part
      assign wr_ok = wr_en && (int'(wr_idx) < NUM_ENTRIES);
      assign rd_ok = int'(rd_idx) < NUM_ENTRIES;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            tbl[i] <= rtable_reset_entry(i, NUM_PORTS);
         end
      end else if (wr_ok) begin
         tbl[wr_idx] <= wr_entry;
      end
   end

   // Readback samples the pre-write table, so a same-cycle write shows up a cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_entry <= rtable_reset_entry(0, NUM_PORTS);
      end else begin
         rd_entry <= rd_ok ? tbl[rd_idx] : '0;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      pf_vf_rtable_match #(
         .NUM_ENTRIES  (NUM_ENTRIES),
         .PF_WIDTH     (PF_WIDTH),
         .VF_WIDTH     (VF_WIDTH),
         .PORT_W       (PORT_W),
         .DEFAULT_PORT (DEFAULT_PORT)
      ) u_match (
         .clk           (clk),
         .rst_n         (rst_n),
         .tbl           (tbl),
         .req_valid     (req_valid[c]),
         .req_ready     (req_ready[c]),
         .req_pf        (req_pf[c]),
         .req_vf        (req_vf[c]),
         .req_vf_active (req_vf_active[c]),
         .resp_valid    (resp_valid[c]),
         .resp_ready    (resp_ready[c]),
         .resp_port     (resp_port[c]),
         .resp_hit      (resp_hit[c]),
         .miss_cnt      (miss_cnt[c]),
         .miss_cnt_clr  (miss_cnt_clr)
      );
   end

endmodule

// File: tb/tb_pf_vf_rtable_lookup.sv
// Purpose  : directed self-checking bench for pf_vf_rtable_lookup (default parameters).
// Latency  : expects responses 2 cycles after acceptance, rd_entry 1 cycle after rd_idx.
// Backpres.: exercises a 5-cycle resp_ready stall on channel 0 while channel 1 streams.
module tb_pf_vf_rtable_lookup;
   import pf_vf_rtable_pkg::*;

   localparam int NUM_CH = 2;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic                       wr_en;
   logic [3:0]                 wr_idx;
   t_rtable_entry              wr_entry;
   logic [3:0]                 rd_idx;
   t_rtable_entry              rd_entry;
   logic [NUM_CH-1:0]          req_valid;
   logic [NUM_CH-1:0]          req_ready;
   logic [NUM_CH-1:0][2:0]     req_pf;
   logic [NUM_CH-1:0][10:0]    req_vf;
   logic [NUM_CH-1:0]          req_vf_active;
   logic [NUM_CH-1:0]          resp_valid;
   logic [NUM_CH-1:0]          resp_ready;
   logic [NUM_CH-1:0][2:0]     resp_port;
   logic [NUM_CH-1:0]          resp_hit;
   logic [NUM_CH-1:0][15:0]    miss_cnt;
   logic                       miss_cnt_clr;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   pf_vf_rtable_lookup dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_en         (wr_en),
      .wr_idx        (wr_idx),
      .wr_entry      (wr_entry),
      .rd_idx        (rd_idx),
      .rd_entry      (rd_entry),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_pf        (req_pf),
      .req_vf        (req_vf),
      .req_vf_active (req_vf_active),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_port     (resp_port),
      .resp_hit      (resp_hit),
      .miss_cnt      (miss_cnt),
      .miss_cnt_clr  (miss_cnt_clr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic t_rtable_entry mk(input logic v, input logic [2:0] pf, input logic [10:0] vf,
                                        input logic act, input logic [2:0] port);
      t_rtable_entry e;
      e.valid = v; e.pf = pf; e.vf = vf; e.vf_active = act; e.port = port;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int idx, input t_rtable_entry e);
      wr_en = 1'b1; wr_idx = 4'(idx); wr_entry = e;
      tick();
      wr_en = 1'b0;
   endtask

   // Single isolated lookup; checks 2-cycle latency, then lets the handshake complete.
   task automatic lookup(input string tag, input int ch, input logic [2:0] pf, input logic [10:0] vf,
                         input logic act, input logic [2:0] exp_port, input logic exp_hit);
      req_pf[ch] = pf; req_vf[ch] = vf; req_vf_active[ch] = act; req_valid[ch] = 1'b1;
      tick();
      req_valid[ch] = 1'b0;
      check({tag, "_lat1"}, 32'(resp_valid[ch]), 0);
      tick();
      check({tag, "_vld"},  32'(resp_valid[ch]), 1);
      check({tag, "_port"}, 32'(resp_port[ch]), 32'(exp_port));
      check({tag, "_hit"},  32'(resp_hit[ch]), 32'(exp_hit));
      tick();
   endtask

   initial begin
      int acc0, acc1;
      logic [NUM_CH-1:0] rdy;

      rst_n = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_entry = '0; rd_idx = '0;
      req_valid = '0; req_pf = '0; req_vf = '0; req_vf_active = '0;
      resp_ready = '1; miss_cnt_clr = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_req_ready",  32'(req_ready), 3);
      check("rst_resp_valid", 32'(resp_valid), 0);
      check("rst_resp_port",  32'(resp_port), 0);
      check("rst_resp_hit",   32'(resp_hit), 0);
      check("rst_miss_cnt",   32'(miss_cnt), 0);
      check("rst_rd_entry",   32'(rd_entry), 32'(mk(1'b1, 3'd0, 11'd0, 1'b1, 3'd0)));
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Reset map lookups
      lookup("pf0vf5",    0, 3'd0, 11'd5, 1'b1, 3'd5, 1'b1);
      lookup("pf1inact",  1, 3'd1, 11'd0, 1'b0, 3'd0, 1'b0);
      lookup("pf0vf7",    1, 3'd0, 11'd7, 1'b1, 3'd7, 1'b1);
      lookup("pf0vf9inv", 0, 3'd0, 11'd9, 1'b1, 3'd0, 1'b0);

      // PF-only entry ignores vf
      wr(3, mk(1'b1, 3'd1, 11'd0, 1'b0, 3'd6));
      lookup("pfonly", 0, 3'd1, 11'd123, 1'b0, 3'd6, 1'b1);
      rd_idx = 4'd3;
      tick();
      check("rd_entry3", 32'(rd_entry), 32'(mk(1'b1, 3'd1, 11'd0, 1'b0, 3'd6)));

      // Lowest index wins, then fall through to the next match
      wr(2, mk(1'b1, 3'd2, 11'd0, 1'b0, 3'd4));
      wr(9, mk(1'b1, 3'd2, 11'd0, 1'b0, 3'd7));
      lookup("prio2",      0, 3'd2, 11'd0, 1'b0, 3'd4, 1'b1);
      lookup("actmis",     1, 3'd2, 11'd0, 1'b1, 3'd0, 1'b0);
      wr(2, mk(1'b0, 3'd2, 11'd0, 1'b0, 3'd4));
      lookup("prio9",      1, 3'd2, 11'd0, 1'b0, 3'd7, 1'b1);

      // Write and request in the same cycle: old port; next cycle: new port
      wr_en = 1'b1; wr_idx = 4'd5; wr_entry = mk(1'b1, 3'd0, 11'd5, 1'b1, 3'd2);
      req_pf = '0; req_vf[0] = 11'd5; req_vf[1] = 11'd5; req_vf_active = 2'b11;
      req_valid = 2'b01;
      tick();
      wr_en = 1'b0;
      req_valid = 2'b10;
      tick();
      req_valid = 2'b00;
      check("samecyc_vld",  32'(resp_valid[0]), 1);
      check("samecyc_old",  32'(resp_port[0]), 5);
      tick();
      check("nextcyc_vld",  32'(resp_valid[1]), 1);
      check("nextcyc_new",  32'(resp_port[1]), 2);
      tick(); tick();

      // Channel 0 stalled for 5 cycles while both channels stream
      acc0 = 0; acc1 = 0;
      resp_ready = 2'b10;
      req_pf = '0; req_vf_active = 2'b11;
      for (int k = 0; k < 5; k++) begin
         req_valid = 2'b11;
         req_vf[0] = 11'(1 + acc0);
         req_vf[1] = 11'(k);
         if (k >= 2) begin
            check("bp_hold_vld",  32'(resp_valid[0]), 1);
            check("bp_hold_port", 32'(resp_port[0]), 1);
            check("bp_hold_hit",  32'(resp_hit[0]), 1);
            check("bp_ch1_vld",   32'(resp_valid[1]), 1);
         end
         rdy = req_ready;
         tick();
         if (rdy[0]) acc0++;
         if (rdy[1]) acc1++;
      end
      check("bp_ch0_accepts", 32'(acc0), 2);
      check("bp_ch1_accepts", 32'(acc1), 5);
      check("bp_ch0_ready",   32'(req_ready[0]), 0);
      req_valid = 2'b00;
      resp_ready = 2'b11;
      tick();
      // Second queued key (pf0,vf2) misses: entry 2 was repurposed.
      check("bp_drain_vld", 32'(resp_valid[0]), 1);
      check("bp_drain_hit", 32'(resp_hit[0]), 0);
      check("bp_drain_port", 32'(resp_port[0]), 0);
      tick(); tick();
      check("bp_idle", 32'(resp_valid), 0);

`ifdef PF_VF_RTABLE_MISS_CNT_EN
      miss_cnt_clr = 1'b1;
      tick();
      miss_cnt_clr = 1'b0;
      check("mc_clr", 32'(miss_cnt[0]), 0);
      lookup("mc_m1", 0, 3'd7, 11'd0, 1'b0, 3'd0, 1'b0);
      lookup("mc_m2", 0, 3'd7, 11'd0, 1'b0, 3'd0, 1'b0);
      check("mc_two", 32'(miss_cnt[0]), 2);
      req_pf[0] = 3'd7; req_vf_active[0] = 1'b0; req_valid[0] = 1'b1;
      repeat (70000) tick();
      check("mc_sat", 32'(miss_cnt[0]), 32'hFFFF);
      check("mc_sat_vld", 32'(resp_valid[0] & ~resp_hit[0]), 1);
      miss_cnt_clr = 1'b1;
      tick();
      miss_cnt_clr = 1'b0;
      check("mc_clr_wins", 32'(miss_cnt[0]), 0);
      req_valid[0] = 1'b0;
      tick(); tick(); tick();
`else
      check("mc_off0", 32'(miss_cnt[0]), 0);
      check("mc_off1", 32'(miss_cnt[1]), 0);
`endif

      // Mid-flight reset flushes the pipe and restores the table
      req_pf[0] = 3'd1; req_vf[0] = 11'd0; req_vf_active[0] = 1'b0; req_valid[0] = 1'b1;
      tick();
      req_valid[0] = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mid_rst_vld",   32'(resp_valid), 0);
      check("mid_rst_ready", 32'(req_ready), 3);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_vld", 32'(resp_valid), 0);
      lookup("post_rst_pf1", 0, 3'd1, 11'd0, 1'b0, 3'd0, 1'b0);
      lookup("post_rst_vf3", 1, 3'd0, 11'd3, 1'b1, 3'd3, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
